if_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the memory arbiter. It issues four sequential byte reads per instruction through the arbiter's instruction port and assembles the returned bytes little-endian into a 32-bit word. It presents that word with its PC to IF/ID through a valid/ready handshake and redirects on branch. An optional direct-mapped instruction cache short-circuits memory on hits.

---
 rtl/if_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: four byte reads per word through the arbiter, valid/ready hand-off to IF/ID.
// Define ICACHE_EN to add a direct-mapped one-word-per-line instruction cache.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        inst_ce,
  output logic [31:0] if_inst_addr,
  input  logic [7:0]  mem_din,
  input  logic        data_busy,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        id_ready,
  input  logic        br_en,
  input  logic [31:0] br_target
);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        buf_q, buf_d;
  logic [CNT_W-1:0]   ic_q, ic_d;
  logic [CNT_W-1:0]   rc_q, rc_d;
  logic               pend_q, pend_d;
  logic               valid_q, valid_d;
  logic               cache_hit_c;
  logic [31:0]        cache_rdata_c;

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  // Request is gated by rdy in the same cycle, so it is decoded rather than registered.
  assign inst_ce      = rdy && (state_q == FETCH) && (ic_q != CNT_W'(4));
  assign if_inst_addr = addr_q;
  assign inst_valid   = valid_q;
  assign inst_out     = buf_q;
  assign inst_pc      = fetch_pc_q;

  // Next-state: everything holds unless rdy; a branch overrides any state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    ic_d       = ic_q;
    rc_d       = rc_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          fetch_pc_d = pc_q;
          addr_d     = pc_q;
          ic_d       = '0;
          rc_d       = '0;
          buf_d      = '0;
          pend_d     = 1'b0;
          if (cache_hit_c) begin
            buf_d   = cache_rdata_c;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          pend_d = 1'b0;
          if (pend_q) begin
            buf_d[{rc_q[1:0], 3'b000} +: 8] = mem_din;
            rc_d = rc_q + CNT_W'(1);
          end
          if (ic_q != CNT_W'(4) && !data_busy) begin
            ic_d   = ic_q + CNT_W'(1);
            addr_d = addr_q + 32'd1;
            pend_d = 1'b1;
          end
          if (rc_d == CNT_W'(4)) begin
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (br_en) begin
        pc_d    = br_target;
        valid_d = 1'b0;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      ic_q       <= '0;
      rc_q       <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      ic_q       <= ic_d;
      rc_q       <= rc_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
    end
  end

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [31:0]             line_data_q [ICACHE_LINES];
  logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_vld_q;
  logic [IDX_W-1:0]        rd_idx_c, wr_idx_c;
  logic                    cache_we_c;

  assign rd_idx_c      = pc_q[IDX_W+1:2];
  assign wr_idx_c      = fetch_pc_q[IDX_W+1:2];
  assign cache_hit_c   = line_vld_q[rd_idx_c] && (line_tag_q[rd_idx_c] == pc_q[31:IDX_W+2]);
  assign cache_rdata_c = line_data_q[rd_idx_c];
  // Only a fetch that completes without a branch in the same cycle fills its line.
  assign cache_we_c    = rdy && !br_en && (state_q == FETCH) && (state_d == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld_q <= '0;
    end else if (cache_we_c) begin
      line_vld_q[wr_idx_c] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cache_we_c) begin
      line_data_q[wr_idx_c] <= buf_d;
      line_tag_q[wr_idx_c]  <= fetch_pc_q[31:IDX_W+2];
    end
  end
`else
  assign cache_hit_c   = 1'b0;
  assign cache_rdata_c = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing scenarios plus a randomized run against a
// transaction-level model (expected PC stream and memory contents).
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        inst_ce;
  logic [31:0] if_inst_addr;
  logic [7:0]  mem_din = 8'h00;
  logic        data_busy = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        id_ready = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .ICACHE_LINES(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .inst_ce(inst_ce), .if_inst_addr(if_inst_addr),
    .mem_din(mem_din), .data_busy(data_busy), .inst_valid(inst_valid), .inst_out(inst_out),
    .inst_pc(inst_pc), .id_ready(id_ready), .br_en(br_en), .br_target(br_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: program bytes at 0..3, a fixed scramble elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return 8'(a ^ (a >> 8) ^ (a >> 17)) ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Arbiter/memory: a granted request returns its byte next cycle; held while rdy is low.
  logic        g_ok = 1'b0;
  logic        g_rdy = 1'b0;
  logic [31:0] g_addr = 32'h0;
  always @(negedge clk) begin
    g_ok   = inst_ce && !data_busy;
    g_rdy  = rdy;
    g_addr = if_inst_addr;
  end
  always @(posedge clk) begin
    if (g_rdy) mem_din <= g_ok ? mem_byte(g_addr) : 8'($urandom);
  end

  // Reference model: expected PC stream and per-instruction request addresses.
  logic [31:0] exp_pc = RESET_PC;
  int          req_cnt = 0;
  bit          br_prev = 1'b0;
  int          n_acc = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc  = RESET_PC;
      req_cnt = 0;
      br_prev = 1'b0;
    end else if (!rdy) begin
      chk("ce_while_not_rdy", 32'(inst_ce), 32'd0);
    end else begin
      if (br_prev) chk("valid_after_branch", 32'(inst_valid), 32'd0);
      if (inst_valid) begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_out", inst_out, mem_word(exp_pc));
      end
      if (inst_ce && !data_busy && !br_en) begin
        chk("req_addr", if_inst_addr, exp_pc + 32'(req_cnt));
        req_cnt++;
      end
      if (inst_valid && id_ready) begin
        n_acc++;
        exp_pc  = exp_pc + 32'd4;
        req_cnt = 0;
      end
      if (br_en) begin
        exp_pc  = br_target;
        req_cnt = 0;
      end
      br_prev = br_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE (cycle 0) with rst released.
  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; data_busy = 1'b0; id_ready = 1'b0; br_en = 1'b0; br_target = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h100;
      2:       return 32'h40;
      3:       return 32'hFFFF_FFF8;
      4:       return 32'hFFFF_FFFC;
      default: return 32'({$urandom_range(0, 255), 2'b00});
    endcase
  endfunction

  int acc_before;

  initial begin
    // Reset values and the plain miss path
    do_reset();
    chk("rst_ce", 32'(inst_ce), 32'd0);
    chk("rst_addr", if_inst_addr, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_out", inst_out, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) begin
        chk("miss_ce", 32'(inst_ce), 32'd1);
        chk("miss_addr", if_inst_addr, 32'(k - 1));
      end else begin
        chk("miss_ce_off", 32'(inst_ce), 32'd0);
      end
      chk("miss_valid", 32'(inst_valid), 32'(k == 6));
    end
    chk("miss_word", inst_out, 32'h0010_0513);
    chk("miss_pc", inst_pc, 32'd0);

    // One data_busy cycle on the second request
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    chk("busy_addr_c2", if_inst_addr, 32'd1);
    data_busy = 1'b1;
    tick();
    data_busy = 1'b0;
    chk("busy_ce_c3", 32'(inst_ce), 32'd1);
    chk("busy_reissue", if_inst_addr, 32'd1);
    tick(); tick(); tick();
    chk("busy_valid_c6", 32'(inst_valid), 32'd0);
    tick();
    chk("busy_valid_c7", 32'(inst_valid), 32'd1);
    chk("busy_word", inst_out, 32'h0010_0513);

    // Back-pressure in HOLD
    do_reset();
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_out", inst_out, 32'h0010_0513);
      chk("hold_pc", inst_pc, 32'd0);
      chk("hold_ce", 32'(inst_ce), 32'd0);
      tick();
    end
    id_ready = 1'b1;
    chk("hold_valid_last", 32'(inst_valid), 32'd1);
    tick();
    id_ready = 1'b0;
    chk("hold_idle_ce", 32'(inst_ce), 32'd0);
    chk("hold_idle_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("hold_next_ce", 32'(inst_ce), 32'd1);
    chk("hold_next_addr", if_inst_addr, 32'd4);

    // Branch while two bytes are captured
    do_reset();
    id_ready = 1'b1;
    repeat (4) tick();
    br_en = 1'b1; br_target = 32'h100;
    tick();
    br_en = 1'b0;
    chk("br_idle_ce", 32'(inst_ce), 32'd0);
    chk("br_idle_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("br_ce", 32'(inst_ce), 32'd1);
      chk("br_addr", if_inst_addr, 32'h100 + 32'(k));
    end
    tick();
    chk("br_valid_c10", 32'(inst_valid), 32'd0);
    tick();
    chk("br_valid_c11", 32'(inst_valid), 32'd1);
    chk("br_pc", inst_pc, 32'h100);
    chk("br_word", inst_out, mem_word(32'h100));

    // rdy low for three cycles mid-fetch
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    rdy = 1'b0;
    #1;
    chk("rdy_ce_c2", 32'(inst_ce), 32'd0);
    tick();
    chk("rdy_ce_c3", 32'(inst_ce), 32'd0);
    tick();
    chk("rdy_ce_c4", 32'(inst_ce), 32'd0);
    tick();
    rdy = 1'b1;
    #1;
    chk("rdy_resume_ce", 32'(inst_ce), 32'd1);
    chk("rdy_resume_addr", if_inst_addr, 32'd1);
    tick(); tick(); tick();
    chk("rdy_valid_c8", 32'(inst_valid), 32'd0);
    tick();
    chk("rdy_valid_c9", 32'(inst_valid), 32'd1);
    chk("rdy_word", inst_out, 32'h0010_0513);

`ifdef ICACHE_EN
    // Two-instruction loop: second pass served from the cache
    do_reset();
    id_ready = 1'b1;
    repeat (13) tick();
    chk("loop_valid_pc4", 32'(inst_valid), 32'd1);
    chk("loop_pc4", inst_pc, 32'd4);
    br_en = 1'b1; br_target = 32'h0;
    tick();
    br_en = 1'b0;
    chk("loop_idle_ce", 32'(inst_ce), 32'd0);
    tick();
    chk("hit0_valid", 32'(inst_valid), 32'd1);
    chk("hit0_pc", inst_pc, 32'd0);
    chk("hit0_ce", 32'(inst_ce), 32'd0);
    chk("hit0_word", inst_out, 32'h0010_0513);
    tick();
    chk("hit_idle_ce", 32'(inst_ce), 32'd0);
    tick();
    chk("hit4_valid", 32'(inst_valid), 32'd1);
    chk("hit4_pc", inst_pc, 32'd4);
    chk("hit4_word", inst_out, mem_word(32'd4));
`endif

    // Randomized run checked by the reference model
    do_reset();
    acc_before = n_acc;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst       = ($urandom_range(0, 299) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      data_busy = ($urandom_range(0, 2) == 0);
      id_ready  = ($urandom_range(0, 4) != 0);
      br_en     = rdy && ($urandom_range(0, 29) == 0);
      br_target = pick_target();
    end
    tick();
    rst = 1'b0; br_en = 1'b0; rdy = 1'b1;
    chk("random_progress", 32'(n_acc - acc_before >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
